// File: rtl/hub75_rx.sv
// HUB75 bus receiver: rebuilds pixel writes, line commits and OE pulse widths
// from a HUB75 stream sampled on the system clock.
module hub75_rx #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned PLANES = 6,
  parameter int unsigned OE_W   = 12
) (
  input  logic            clk_in,
  input  logic            reset_n,
  input  logic            hub_clk,
  input  logic            hub_lat,
  input  logic            hub_oe,
  input  logic [3:0]      hub_addr,
  input  logic [5:0]      hub_rgb,
  output logic            pix_valid,
  output logic [5:0]      pix_col,
  output logic [5:0]      pix_rgb,
  output logic            line_valid,
  output logic [3:0]      line_row,
  output logic [2:0]      line_plane,
  output logic [6:0]      line_count,
  output logic            line_err,
  output logic            oe_valid,
  output logic [OE_W-1:0] oe_width
);

  localparam int unsigned CW = 7;
  localparam int unsigned PW = 3;

  // [0]/[1] form the synchroniser, [2] is the edge-detect reference
  logic [2:0]      clk_sr, lat_sr, oe_sr;
  logic [3:0]      addr_s1, addr_s2;
  logic [5:0]      rgb_s1, rgb_s2;

  logic [CW-1:0]   col;
  logic            ovr;
  logic            row_valid;
  logic [OE_W-1:0] oe_cnt;

  logic            clk_rise, lat_rise, oe_fall;
  logic            pix_take, pix_ovr, ovr_eff, same_row;
  logic [CW-1:0]   col_eff, cnt_next;
  logic [PW-1:0]   plane_next;

  // Synchronise every HUB75 input through the same two-flop path
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      clk_sr  <= '0;
      lat_sr  <= '0;
      oe_sr   <= '0;
      addr_s1 <= '0;
      addr_s2 <= '0;
      rgb_s1  <= '0;
      rgb_s2  <= '0;
    end else begin
      clk_sr  <= {clk_sr[1:0], hub_clk};
      lat_sr  <= {lat_sr[1:0], hub_lat};
      oe_sr   <= {oe_sr[1:0], hub_oe};
      addr_s1 <= hub_addr;
      addr_s2 <= addr_s1;
      rgb_s1  <= hub_rgb;
      rgb_s2  <= rgb_s1;
    end
  end

  // Edge detection and line bookkeeping; a pixel coinciding with a latch counts in that line
  always_comb begin
    clk_rise   = clk_sr[1] & ~clk_sr[2];
    lat_rise   = lat_sr[1] & ~lat_sr[2];
    oe_fall    = ~oe_sr[1] & oe_sr[2];
    pix_take   = clk_rise && (col < CW'(WIDTH));
    pix_ovr    = clk_rise && (col == CW'(WIDTH));
    col_eff    = col + CW'(pix_take);
    ovr_eff    = ovr | pix_ovr;
    cnt_next   = col_eff + CW'(ovr_eff);
    same_row   = row_valid && (addr_s2 == line_row);
    plane_next = '0;
    if (same_row && (line_plane != PW'(PLANES - 1))) begin
      plane_next = line_plane + PW'(1);
    end
  end

  // Pixel and line outputs plus the column counter
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid  <= 1'b0;
      pix_col    <= '0;
      pix_rgb    <= '0;
      line_valid <= 1'b0;
      line_row   <= '0;
      line_plane <= '0;
      line_count <= '0;
      line_err   <= 1'b0;
      col        <= '0;
      ovr        <= 1'b0;
      row_valid  <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      line_valid <= 1'b0;
      if (pix_take) begin
        pix_valid <= 1'b1;
        pix_col   <= col[5:0];
        pix_rgb   <= rgb_s2;
      end
      if (lat_rise) begin
        line_valid <= 1'b1;
        line_row   <= addr_s2;
        line_plane <= plane_next;
        line_count <= cnt_next;
        line_err   <= (cnt_next != CW'(WIDTH));
        row_valid  <= 1'b1;
        col        <= '0;
        ovr        <= 1'b0;
      end else begin
        col <= col_eff;
        ovr <= ovr_eff;
      end
    end
  end

  // Output-enable pulse width measurement, saturating
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      oe_cnt   <= '0;
      oe_valid <= 1'b0;
      oe_width <= '0;
    end else begin
      oe_valid <= 1'b0;
      if (oe_fall) begin
        oe_valid <= 1'b1;
        oe_width <= oe_cnt;
        oe_cnt   <= '0;
      end else if (oe_sr[1] && (oe_cnt != {OE_W{1'b1}})) begin
        oe_cnt <= oe_cnt + OE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// Scoreboard bench for hub75_rx: stimulus pushes expectations, a monitor pops and compares.
module tb_hub75_rx;

  logic        clk_in   = 1'b0;
  logic        reset_n  = 1'b0;
  logic        hub_clk  = 1'b0;
  logic        hub_lat  = 1'b0;
  logic        hub_oe   = 1'b0;
  logic [3:0]  hub_addr = '0;
  logic [5:0]  hub_rgb  = '0;
  logic        pix_valid, line_valid, line_err, oe_valid;
  logic [5:0]  pix_col, pix_rgb;
  logic [3:0]  line_row;
  logic [2:0]  line_plane;
  logic [6:0]  line_count;
  logic [11:0] oe_width;

  typedef struct packed {
    logic [5:0] col;
    logic [5:0] rgb;
  } pix_t;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] plane;
    logic [6:0] cnt;
    logic       err;
  } line_t;

  pix_t        pix_q[$];
  line_t       line_q[$];
  logic [11:0] oe_q[$];
  pix_t        pe;
  line_t       le;
  logic [11:0] oe_e;

  int tests = 0;
  int fails = 0;
  int tb_col = 0;
  bit chk_idle = 1'b0;
  bit chk_end  = 1'b0;

  hub75_rx #(.WIDTH(64), .PLANES(6), .OE_W(12)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_addr(hub_addr), .hub_rgb(hub_rgb),
    .pix_valid(pix_valid), .pix_col(pix_col), .pix_rgb(pix_rgb),
    .line_valid(line_valid), .line_row(line_row), .line_plane(line_plane),
    .line_count(line_count), .line_err(line_err),
    .oe_valid(oe_valid), .oe_width(oe_width)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: compare every output pulse against the head of its queue
  always @(negedge clk_in) begin
    if (pix_valid) begin
      tests++;
      if (pix_q.size() == 0) begin
        fails++;
        $display("FAIL pix_unexpected: got col=%0d rgb=%0d, expected no pixel", pix_col, pix_rgb);
      end else begin
        pe = pix_q.pop_front();
        if (pix_col != pe.col || pix_rgb != pe.rgb) begin
          fails++;
          $display("FAIL pix: got col=%0d rgb=%0d, expected col=%0d rgb=%0d",
                   pix_col, pix_rgb, pe.col, pe.rgb);
        end
      end
    end
    if (line_valid) begin
      tests++;
      if (line_q.size() == 0) begin
        fails++;
        $display("FAIL line_unexpected: got row=%0d count=%0d, expected no line", line_row, line_count);
      end else begin
        le = line_q.pop_front();
        if (line_row != le.row || line_plane != le.plane ||
            line_count != le.cnt || line_err != le.err) begin
          fails++;
          $display("FAIL line: got row=%0d plane=%0d count=%0d err=%0d, expected row=%0d plane=%0d count=%0d err=%0d",
                   line_row, line_plane, line_count, line_err, le.row, le.plane, le.cnt, le.err);
        end
      end
    end
    if (oe_valid) begin
      tests++;
      if (oe_q.size() == 0) begin
        fails++;
        $display("FAIL oe_unexpected: got width=%0d, expected no pulse", oe_width);
      end else begin
        oe_e = oe_q.pop_front();
        if (oe_width != oe_e) begin
          fails++;
          $display("FAIL oe_width: got %0d, expected %0d", oe_width, oe_e);
        end
      end
    end
    if (chk_idle) begin
      tests++;
      if (pix_valid || line_valid || oe_valid || pix_col != 0 || pix_rgb != 0 ||
          line_row != 0 || line_plane != 0 || line_count != 0 || line_err || oe_width != 0) begin
        fails++;
        $display("FAIL reset_state: got pv=%0d col=%0d rgb=%0d lv=%0d row=%0d plane=%0d cnt=%0d err=%0d ov=%0d w=%0d, expected all 0",
                 pix_valid, pix_col, pix_rgb, line_valid, line_row, line_plane, line_count,
                 line_err, oe_valid, oe_width);
      end
    end
    if (chk_end) begin
      tests++;
      if (pix_q.size() != 0 || line_q.size() != 0 || oe_q.size() != 0) begin
        fails++;
        $display("FAIL drain: got pending pix=%0d line=%0d oe=%0d, expected 0 0 0",
                 pix_q.size(), line_q.size(), oe_q.size());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_idle_check();
    @(posedge clk_in);
    chk_idle = 1'b1;
    @(posedge clk_in);
    chk_idle = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic pixel(input logic [5:0] rgb);
    hub_rgb = rgb;
    cyc(2);
    hub_clk = 1'b1;
    if (tb_col < 64) begin
      pix_q.push_back('{col: 6'(tb_col), rgb: rgb});
      tb_col++;
    end
    cyc(2);
    hub_clk = 1'b0;
  endtask

  task automatic latch(input logic [3:0] addr, input logic [2:0] plane, input logic [6:0] cnt);
    hub_addr = addr;
    cyc(2);
    hub_lat = 1'b1;
    line_q.push_back('{row: addr, plane: plane, cnt: cnt, err: (cnt != 7'd64)});
    cyc(2);
    hub_lat = 1'b0;
    tb_col = 0;
    cyc(2);
  endtask

  task automatic send_line(input int n, input logic [3:0] addr, input logic [2:0] plane,
                           input logic [6:0] cnt);
    for (int i = 0; i < n; i++) pixel(6'(i));
    latch(addr, plane, cnt);
  endtask

  task automatic oe_pulse(input int n, input logic [11:0] w);
    hub_oe = 1'b1;
    cyc(n);
    hub_oe = 1'b0;
    oe_q.push_back(w);
    cyc(6);
  endtask

  initial begin
    int budget;
    cyc(3);
    pulse_idle_check();
    reset_n = 1'b1;
    cyc(3);

    // Nominal full line
    send_line(64, 4'd5, 3'd0, 7'd64);

    // Plane sequence on row 5, wrap after plane 5, then row change
    for (int k = 1; k <= 6; k++) send_line(8, 4'd5, 3'(k % 6), 7'd8);
    send_line(8, 4'd6, 3'd0, 7'd8);
    for (int k = 0; k <= 6; k++) send_line(8, 4'd5, 3'(k % 6), 7'd8);

    // Short line, overrun line, then a clean line restarting at column 0
    send_line(10, 4'd2, 3'd0, 7'd10);
    send_line(70, 4'd2, 3'd1, 7'd65);
    send_line(64, 4'd2, 3'd2, 7'd64);

    // 64th pixel edge and latch edge in the same cycle
    for (int i = 0; i < 63; i++) pixel(6'(i));
    hub_rgb  = 6'h2a;
    hub_addr = 4'd2;
    cyc(2);
    hub_clk = 1'b1;
    hub_lat = 1'b1;
    pix_q.push_back('{col: 6'd63, rgb: 6'h2a});
    line_q.push_back('{row: 4'd2, plane: 3'd3, cnt: 7'd64, err: 1'b0});
    cyc(2);
    hub_clk = 1'b0;
    hub_lat = 1'b0;
    tb_col = 0;
    cyc(4);

    // OE pulse widths, nominal and saturating
    oe_pulse(130, 12'd130);
    oe_pulse(5000, 12'd4095);

    // Reset mid-line: partial line dropped, row history forgotten
    for (int i = 0; i < 20; i++) pixel(6'(i));
    cyc(6);
    reset_n = 1'b0;
    cyc(2);
    pulse_idle_check();
    reset_n = 1'b1;
    tb_col = 0;
    cyc(3);
    send_line(64, 4'd2, 3'd0, 7'd64);

    budget = 0;
    while ((pix_q.size() != 0 || line_q.size() != 0 || oe_q.size() != 0) && budget < 500) begin
      cyc(1);
      budget++;
    end
    @(posedge clk_in);
    chk_end = 1'b1;
    @(posedge clk_in);
    chk_end = 1'b0;
    @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receive-side counterpart of the panel scan driver: samples a HUB75 bus (pixel clock, latch, output enable, row address, 6-bit RGB) on the system clock.
- Reconstructs the stream into pixel writes, per-line commit events (row, brightness plane, pixel count) and output-enable pulse widths.
- Used as a loopback/verification monitor and as the input stage for a daisy-chained panel.

Parameters:
- WIDTH, 64, pixels expected per line; must be <= 64.
- PLANES, 6, brightness planes per row, sent MSB first.
- OE_W, 12, width of the output-enable pulse-width counter.

Ports:
- clk_in  input  1  system clock; must be >= 4x the HUB75 pixel clock.
- reset_n  input  1  asynchronous, active-low reset.
- hub_clk  input  1  HUB75 pixel clock; data is valid on its rising edge.
- hub_lat  input  1  HUB75 row latch; commits on its rising edge.
- hub_oe  input  1  HUB75 output enable; high = LEDs on.
- hub_addr  input  4  HUB75 row address.
- hub_rgb  input  6  {r0,g0,b0,r1,g1,b1}.
- pix_valid  output  1  single-cycle pulse: one pixel received.
- pix_col  output  6  arrival index of the pixel, 0 = first after a latch.
- pix_rgb  output  6  pixel data.
- line_valid  output  1  single-cycle pulse: line committed.
- line_row  output  4  row address sampled at the latch.
- line_plane  output  3  brightness plane index of the committed line.
- line_count  output  7  pixels received since the previous latch.
- line_err  output  1  line_count != WIDTH; qualified by line_valid.
- oe_valid  output  1  single-cycle pulse: OE pulse ended.
- oe_width  output  OE_W  clk_in cycles OE was high; saturating.

Behaviour:
- Synchronisation:
  - All hub_* inputs pass through a 2-flop synchroniser into clk_in.
  - Edges are detected against a third registered copy.
  - Data and address take the same synchroniser path as their strobes, so skew is preserved.
- Pixel path, on a detected hub_clk rising edge:
  - If the column counter < WIDTH: pix_valid=1, pix_rgb = synced hub_rgb, pix_col = counter, then counter++.
  - If the counter == WIDTH: no pix_valid; set the internal overrun flag.
  - Latency: the pin edge appears as pix_valid on the 3rd clk_in rising edge.
- Line path, on a detected hub_lat rising edge:
  - line_valid=1, line_row = synced hub_addr, line_count = column counter + overrun flag.
  - line_err = (line_count != WIDTH).
  - Then clear the column counter and the overrun flag.
  - line_count saturates at WIDTH+1 to indicate overrun.
- Plane tracking:
  - line_plane = 0 if line_row differs from the row of the previous commit, or this is the first commit after reset.
  - Otherwise line_plane = previous plane + 1, wrapping at PLANES-1 -> 0.
- Simultaneous hub_clk and hub_lat edges in the same cycle:
  - The pixel is emitted first (pix_valid at its current column).
  - It is included in that line's line_count.
  - The counter then restarts at 0.
- OE path:
  - While synced hub_oe is high, the counter increments, saturating at all-ones.
  - On its falling edge: oe_valid=1, oe_width = count (including the last high cycle), then the counter clears.
  - OE high across reset deassertion counts from 0.
- Output hold: pix_*, line_* and oe_width hold their last values between pulses.
- Reset (reset_n low, asynchronous):
  - All outputs and counters = 0; synchroniser flops = 0; "previous row" = invalid.
  - Because synchroniser flops reset to 0, an input already high at reset release registers a rising edge about 2 cycles later. This is accepted: the bench must hold hub_* low across reset release.
  - Reset mid-line discards the partial line; no line_valid is issued.
- Input timing: each hub_clk, hub_lat and hub_oe high/low phase must be >= 2 clk_in periods. Shorter pulses are not required to be detected.

Test Plan:
- Nominal line: reset; 64 hub_clk pulses with rgb = column index; latch with addr=5 -> 64 pix_valid, pix_col 0..63, pix_rgb matching; line_valid with row=5, plane=0, count=64, err=0.
- Plane sequence: 6 lines at addr=5 then 1 line at addr=6 -> line_plane 0,1,2,3,4,5 then 0; a 7th line at addr=5 wraps to 0.
- Short/overrun: 10 pixels then latch -> count=10, err=1; 70 pixels then latch -> only 64 pix_valid, count=65, err=1; next line starts at pix_col 0.
- Coincident edges: the 64th hub_clk rising edge and the hub_lat rising edge in the same clk_in cycle -> pix_valid with col=63, line_count=64, err=0.
- OE width: OE high for 130 clk_in cycles -> oe_valid with oe_width=130; OE high for 5000 cycles with OE_W=12 -> oe_width=4095.
- Reset mid-line: assert reset_n low after 20 pixels, release with inputs low, send a full line -> no line_valid for the partial line; next line count=64, plane=0.
